// File: rtl/pool_pkg.sv
// Shared constants and helpers for the pooling datapath (window generator and max_pool2d).
package pool_pkg;

    localparam int POOL_K_DEF     = 2;
    localparam int POOL_WIDTH_DEF = 16;

    // Flattened element index of window row r, column c.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

    // Bits needed to index v entries, never less than one.
    function automatic int clog2_min1(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// K-1 buffered lines of IMG_W pixels; one write port, one read port per line at a shared column.
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int K     = POOL_K_DEF,
    parameter int WIDTH = POOL_WIDTH_DEF,
    parameter int IMG_W = 8,
    localparam int LW   = clog2_min1(K - 1),
    localparam int CW   = clog2_min1(IMG_W)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [LW-1:0]            wr_line,
    input  logic [CW-1:0]            wr_col,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [CW-1:0]            rd_col,
    output logic [(K-1)*WIDTH-1:0]   rd_data
);

    for (genvar l = 0; l < K - 1; l++) begin : g_line
        logic [WIDTH-1:0] line_mem [IMG_W];

        always_ff @(posedge clk) begin
            if (wr_en && wr_line == LW'(l)) line_mem[wr_col] <= wr_data;
        end

        assign rd_data[WIDTH*l +: WIDTH] = line_mem[rd_col];
    end

endmodule

// File: rtl/pool_window_gen.sv
// Raster-stream to non-overlapping KxK window generator feeding max_pool2d.
// Optional POOL_WIN_SOF_EN adds in_sof to force the accepted pixel to position (0,0).
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int K     = POOL_K_DEF,
    parameter int WIDTH = POOL_WIDTH_DEF,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_pixel,
    input  logic                     in_valid,
`ifdef POOL_WIN_SOF_EN
    input  logic                     in_sof,
`endif
    output logic                     in_ready,
    output logic [WIDTH*K*K-1:0]     window_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int CW = clog2_min1(IMG_W);
    localparam int RW = clog2_min1(IMG_H);
    localparam int PW = clog2_min1(K);
    localparam int LW = clog2_min1(K - 1);

    if (K < 2 || (IMG_W % K) != 0 || (IMG_H % K) != 0) begin : g_param_err
        $fatal(1, "pool_window_gen: K must be >= 2 and divide IMG_W and IMG_H");
    end

    logic [CW-1:0]            col, cur_col;
    logic [RW-1:0]            row, cur_row;
    logic [PW-1:0]            cphase, rphase, cur_cphase, cur_rphase;
    logic                     sof, accept, complete, col_wrap, frame_end;
    logic [(K-1)*WIDTH-1:0]   lb_rd;
    logic [WIDTH-1:0]         col_vec [K];
    logic [WIDTH-1:0]         hist [K][K-1];
    logic [WIDTH*K*K-1:0]     win_next;

`ifdef POOL_WIN_SOF_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    // Position of the pixel on the input this cycle; a start-of-frame pixel is (0,0).
    always_comb begin
        cur_col    = sof ? '0 : col;
        cur_row    = sof ? '0 : row;
        cur_cphase = sof ? '0 : cphase;
        cur_rphase = sof ? '0 : rphase;
    end

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_wrap  = (cur_col == CW'(IMG_W - 1));
    assign frame_end = (cur_row == RW'(IMG_H - 1)) && col_wrap;
    assign complete  = accept && (cur_rphase == PW'(K - 1)) && (cur_cphase == PW'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            cphase <= '0;
            rphase <= '0;
        end else if (accept) begin
            col    <= col_wrap ? '0 : cur_col + CW'(1);
            cphase <= (cur_cphase == PW'(K - 1)) ? '0 : cur_cphase + PW'(1);
            if (col_wrap) begin
                row    <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
                rphase <= (cur_rphase == PW'(K - 1)) ? '0 : cur_rphase + PW'(1);
            end else begin
                row    <= cur_row;
                rphase <= cur_rphase;
            end
        end
    end

    pool_line_buffer #(
        .K     (K),
        .WIDTH (WIDTH),
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept && (cur_rphase < PW'(K - 1))),
        .wr_line (LW'(cur_rphase)),
        .wr_col  (cur_col),
        .wr_data (in_pixel),
        .rd_col  (cur_col),
        .rd_data (lb_rd)
    );

    // Column of the window being assembled: buffered lines on top, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) col_vec[r] = lb_rd[WIDTH*r +: WIDTH];
        col_vec[K-1] = in_pixel;
    end

    // Earlier K-1 columns of the current window, oldest at index 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int j = 0; j < K - 2; j++) hist[r][j] <= hist[r][j+1];
                hist[r][K-2] <= col_vec[r];
            end
        end
    end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_next[WIDTH*win_idx(r, c, K) +: WIDTH] = hist[r][c];
            win_next[WIDTH*win_idx(r, K - 1, K) +: WIDTH] = col_vec[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            window_flat <= '0;
        end else if (complete) begin
            window_flat <= win_next;
            out_valid   <= 1'b1;
            out_last    <= frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen with K=2 on a 4x2 frame.
module tb_pool_window_gen;

    localparam int K     = 2;
    localparam int WIDTH = 16;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [WIDTH-1:0]       in_pixel;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*K*K-1:0]   window_flat;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
`ifdef POOL_WIN_SOF_EN
    logic                   in_sof;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pool_window_gen #(
        .K     (K),
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_pixel    (in_pixel),
        .in_valid    (in_valid),
`ifdef POOL_WIN_SOF_EN
        .in_sof      (in_sof),
`endif
        .in_ready    (in_ready),
        .window_flat (window_flat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    function automatic logic [63:0] mk_win(input logic [15:0] e0, input logic [15:0] e1,
                                           input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [15:0] win_max(input logic [63:0] w);
        logic signed [15:0] m, v;
        m = w[15:0];
        for (int i = 1; i < 4; i++) begin
            v = w[16*i +: 16];
            if (v > m) m = v;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] px);
        in_valid = 1'b1;
        in_pixel = px;
        tick();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input logic [63:0] exp, input logic last_exp);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".window"}, window_flat, exp);
        check({tag, ".last"}, 64'(out_last), 64'(last_exp));
    endtask

    initial begin
        logic [15:0] b;
        logic [63:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
`ifdef POOL_WIN_SOF_EN
        in_sof    = 1'b0;
`endif
        tick();
        tick();
        check("rst.valid", 64'(out_valid), 64'(0));
        check("rst.last", 64'(out_last), 64'(0));
        check("rst.window", window_flat, 64'(0));
        check("rst.in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        // Basic frame 0..7
        for (int p = 0; p < 5; p++) send(16'(p));
        check("f1.idle", 64'(out_valid), 64'(0));
        send(16'd5);
        check_win("f1.w0", mk_win(0, 1, 4, 5), 1'b0);
        send(16'd6);
        check("f1.consumed", 64'(out_valid), 64'(0));
        send(16'd7);
        check_win("f1.w1", mk_win(2, 3, 6, 7), 1'b1);
        in_valid = 1'b0;
        tick();
        check("f1.drain.valid", 64'(out_valid), 64'(0));
        check("f1.drain.last", 64'(out_last), 64'(0));

        // Backpressure: hold the first window for 5 cycles with pixel 6 waiting
        for (int p = 0; p < 6; p++) send(16'(p));
        check_win("bp.w0", mk_win(0, 1, 4, 5), 1'b0);
        held      = window_flat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 16'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp.in_ready", 64'(in_ready), 64'(0));
            check("bp.hold.valid", 64'(out_valid), 64'(1));
            check("bp.hold.window", window_flat, mk_win(0, 1, 4, 5));
            check("bp.hold.last", 64'(out_last), 64'(0));
        end
        check("bp.stable", window_flat, held);
        out_ready = 1'b1;
        tick();
        check("bp.release", 64'(out_valid), 64'(0));
        send(16'd7);
        check_win("bp.w1", mk_win(2, 3, 6, 7), 1'b1);

        // Three back-to-back frames at full rate
        for (int f = 0; f < 3; f++) begin
            b = 16'(100 + 16 * f);
            for (int p = 0; p < 8; p++) begin
                check("rate.in_ready", 64'(in_ready), 64'(1));
                send(b + 16'(p));
                if (p == 5)      check_win("rate.w0", mk_win(b, b + 1, b + 4, b + 5), 1'b0);
                else if (p == 7) check_win("rate.w1", mk_win(b + 2, b + 3, b + 6, b + 7), 1'b1);
                else             check("rate.idle", 64'(out_valid), 64'(0));
            end
        end

        // Signed extremes pass through bit-exact
        send(16'h8000); send(16'hffff); send(16'h0000); send(16'h7fff);
        send(16'hfffe); send(16'hfffd);
        check_win("neg.w0", mk_win(16'h8000, 16'hffff, 16'hfffe, 16'hfffd), 1'b0);
        check("neg.max0", 64'(win_max(window_flat)), 64'(16'hffff));
        send(16'h8000); send(16'hffff);
        check_win("neg.w1", mk_win(16'h0000, 16'h7fff, 16'h8000, 16'hffff), 1'b1);
        check("neg.max1", 64'(win_max(window_flat)), 64'(16'h7fff));

        // Asynchronous reset while a window is presented
        for (int p = 0; p < 6; p++) send(16'(p));
        check("arst.pre", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'(0));
        check("arst.window", window_flat, 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Reset after 3 pixels discards the partial frame
        send(16'd50); send(16'd51); send(16'd52);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mrst.valid", 64'(out_valid), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        for (int p = 0; p < 5; p++) send(16'(20 + p));
        check("mrst.idle", 64'(out_valid), 64'(0));
        send(16'd25);
        check_win("mrst.w0", mk_win(20, 21, 24, 25), 1'b0);
        send(16'd26);
        send(16'd27);
        check_win("mrst.w1", mk_win(22, 23, 26, 27), 1'b1);

`ifdef POOL_WIN_SOF_EN
        // Start-of-frame on pixel 2 restarts the raster
        send(16'd0);
        send(16'd1);
        in_sof = 1'b1;
        send(16'd2);
        in_sof = 1'b0;
        for (int p = 3; p < 7; p++) send(16'(p));
        check("sof.idle", 64'(out_valid), 64'(0));
        send(16'd7);
        check_win("sof.w0", mk_win(2, 3, 6, 7), 1'b0);
        send(16'd8);
        send(16'd9);
        check_win("sof.w1", mk_win(4, 5, 8, 9), 1'b1);
`endif

        in_valid = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
